mmu_utlb: RTL and testbench

- Paged MMU with a parametrised, fully-associative micro-TLB of ENTRIES translations.
- Sits between the CPU data port and the memory bus. Translates 4 KiB-page virtual addresses combinationally on a hit.
- On a miss, runs a two-level hardware page walk through the same bus.
- Adds write-protect faults with a fault code, round-robin replacement, and walk abort on base change.

---
 rtl/mmu_utlb.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mmu_utlb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_utlb.sv
`timescale 1ns/1ps
// mmu_utlb: paged MMU with a fully-associative micro-TLB and a two-level
// hardware page walker sharing the CPU's memory bus.
//
// A TLB hit translates combinationally and adds no latency. A miss walks the
// page directory and then the page table through the same bus, fills one
// entry, and the retry hits on the following cycle. The TLB fills the
// lowest-index free slot first and replaces round-robin once it is full.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   mmu_base_i/mmu_we  page-directory base write (also flushes the TLB)
//   mmu_base_o         current base register
//   v_addr_i, v_data_i, v_data_o, v_we_i, v_rd_i, v_ack_o   CPU side
//   addr_o, data_i, data_o, we_o, rd_o, ack_i               memory bus side
//   page_fault         one-cycle fault pulse, coincident with v_ack_o
//   page_fault_addr    faulting virtual address (held until the next fault)
//   page_fault_code    1 = PDE invalid, 2 = PTE invalid, 3 = write to RO page
//
// Optional build macro MMU_BYPASS_EN: when defined, mmu_base_o[0] = 0 selects
// an identity mapping (no walks, no faults) and 1 enables translation.
// Without the macro bit 0 is stored but translation is always on.
module mmu_utlb #(
    parameter int unsigned ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmu_base_i,
    input  logic        mmu_we,
    output logic [31:0] mmu_base_o,
    input  logic [31:0] v_addr_i,
    input  logic [31:0] v_data_i,
    output logic [31:0] v_data_o,
    input  logic        v_we_i,
    input  logic        v_rd_i,
    output logic        v_ack_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        we_o,
    output logic        rd_o,
    input  logic        ack_i,
    output logic        page_fault,
    output logic [31:0] page_fault_addr,
    output logic [1:0]  page_fault_code
);

    localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_WALK_PD = 3'd2;
    localparam logic [2:0] S_WALK_PT = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;

    localparam logic [1:0] FC_PDE = 2'd1;
    localparam logic [1:0] FC_PTE = 2'd2;
    localparam logic [1:0] FC_WP  = 2'd3;

    // State and configuration
    logic [2:0]         r_state;
    logic [31:0]        r_base;

    // TLB storage
    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_wr;
    logic [19:0]        r_vpn [ENTRIES];
    logic [19:0]        r_ppn [ENTRIES];
    logic [PTR_W-1:0]   r_ptr;

    // Walk scratch
    logic [19:0]        r_pde_ppn;
    logic [19:0]        r_pte_ppn;
    logic               r_pte_w;

    // Held fault report
    logic [31:0]        r_fault_addr;
    logic [1:0]         r_fault_code;

    logic [2:0]         w_state_nxt;
    logic               w_hit;
    logic [19:0]        w_hit_ppn;
    logic               w_hit_w;
    logic               w_free_any;
    logic [PTR_W-1:0]   w_free_idx;
    logic [PTR_W-1:0]   w_fill_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               w_fill;
    logic               w_fault;
    logic [1:0]         w_fault_code;
    logic               w_req;
    logic               w_bypass;
    logic               w_flush;
    logic               w_unused_bits;

    // Descriptor bits [11:2] carry no meaning for this MMU
    assign w_unused_bits = ^data_i[11:2];

`ifdef MMU_BYPASS_EN
    assign w_bypass = ~r_base[0];
`else
    assign w_bypass = 1'b0;
`endif

    assign w_req      = v_we_i | v_rd_i;
    assign w_flush    = mmu_we & (r_state != S_INIT);
    assign mmu_base_o = r_base;
    assign v_data_o   = data_i;

    // Tag match; entries are unique so OR-merging the hit payload is safe
    always_comb begin
        w_hit     = 1'b0;
        w_hit_ppn = 20'h0;
        w_hit_w   = 1'b0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (r_valid[i] && (r_vpn[i] == v_addr_i[31:12])) begin
                w_hit     = 1'b1;
                w_hit_ppn = w_hit_ppn | r_ppn[i];
                w_hit_w   = w_hit_w | r_wr[i];
            end
        end
    end

    // Lowest-index invalid entry; scanning downward leaves the lowest winner
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = PTR_W'(i);
            end
        end
    end

    assign w_ptr_nxt  = (r_ptr == PTR_W'(ENTRIES - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_fill_idx = w_free_any ? w_free_idx : r_ptr;

    // Next state, bus steering and fault detection
    always_comb begin
        w_state_nxt  = r_state;
        addr_o       = 32'h0;
        data_o       = v_data_i;
        we_o         = 1'b0;
        rd_o         = 1'b0;
        v_ack_o      = 1'b0;
        w_fault      = 1'b0;
        w_fault_code = 2'd0;
        w_fill       = 1'b0;

        case (r_state)
            S_INIT: begin
                if (ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_bypass) begin
                    addr_o  = v_addr_i;
                    we_o    = v_we_i;
                    rd_o    = v_rd_i;
                    v_ack_o = ack_i;
                end else if (w_hit) begin
                    if (v_we_i && !w_hit_w) begin
                        w_fault      = 1'b1;
                        w_fault_code = FC_WP;
                        v_ack_o      = 1'b1;
                    end else begin
                        addr_o  = {w_hit_ppn, v_addr_i[11:0]};
                        we_o    = v_we_i;
                        rd_o    = v_rd_i;
                        v_ack_o = ack_i;
                    end
                end else if (w_req) begin
                    w_state_nxt = S_WALK_PD;
                end
            end
            S_WALK_PD: begin
                rd_o   = 1'b1;
                addr_o = {r_base[31:12], v_addr_i[31:22], 2'b00};
                if (ack_i) begin
                    if (!data_i[0]) begin
                        w_fault      = 1'b1;
                        w_fault_code = FC_PDE;
                        v_ack_o      = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_state_nxt = S_WALK_PT;
                    end
                end
            end
            S_WALK_PT: begin
                rd_o   = 1'b1;
                addr_o = {r_pde_ppn, v_addr_i[21:12], 2'b00};
                if (ack_i) begin
                    if (!data_i[0]) begin
                        w_fault      = 1'b1;
                        w_fault_code = FC_PTE;
                        v_ack_o      = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                w_fill      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase

        // A base change abandons any walk silently; the CPU request stays
        // pending and re-walks against the new base.
        if (w_flush) begin
            w_state_nxt = S_IDLE;
            w_fill      = 1'b0;
            if (r_state == S_WALK_PD || r_state == S_WALK_PT) begin
                w_fault      = 1'b0;
                w_fault_code = 2'd0;
                v_ack_o      = 1'b0;
            end
        end
    end

    // Fault report is visible in the fault cycle itself, then held
    assign page_fault      = w_fault;
    assign page_fault_addr = w_fault ? v_addr_i : r_fault_addr;
    assign page_fault_code = w_fault ? w_fault_code : r_fault_code;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Base, TLB contents, walk scratch and fault report
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base       <= 32'h0;
            r_valid      <= '0;
            r_wr         <= '0;
            r_ptr        <= '0;
            r_pde_ppn    <= 20'h0;
            r_pte_ppn    <= 20'h0;
            r_pte_w      <= 1'b0;
            r_fault_addr <= 32'h0;
            r_fault_code <= 2'd0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_vpn[i] <= 20'h0;
                r_ppn[i] <= 20'h0;
            end
        end else begin
            if (w_fault) begin
                r_fault_addr <= v_addr_i;
                r_fault_code <= w_fault_code;
            end
            if (r_state == S_WALK_PD && ack_i) begin
                r_pde_ppn <= data_i[31:12];
            end
            if (r_state == S_WALK_PT && ack_i) begin
                r_pte_ppn <= data_i[31:12];
                r_pte_w   <= data_i[1];
            end
            if (w_flush) begin
                r_base  <= mmu_base_i;
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
                r_wr[w_fill_idx]    <= r_pte_w;
                r_vpn[w_fill_idx]   <= v_addr_i[31:12];
                r_ppn[w_fill_idx]   <= r_pte_ppn;
                if (!w_free_any) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmu_utlb.sv
`timescale 1ns/1ps
// Directed bench for mmu_utlb: a table-driven bus memory answers reads in the
// same cycle, every observed bus transfer and fault is matched against a
// queue of expected events filled by the stimulus steps.
module tb_mmu_utlb;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_FLT = 2'd2;
    localparam int MEM_N = 24;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  code;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mmu_base_i;
    logic        mmu_we;
    logic [31:0] mmu_base_o;
    logic [31:0] v_addr_i;
    logic [31:0] v_data_i;
    logic [31:0] v_data_o;
    logic        v_we_i;
    logic        v_rd_i;
    logic        v_ack_o;
    logic [31:0] addr_o;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        we_o;
    logic        rd_o;
    logic        ack_i;
    logic        page_fault;
    logic [31:0] page_fault_addr;
    logic [1:0]  page_fault_code;

    logic        init_ack;
    logic        mem_on;
    logic        mem_stall;
    logic [31:0] mem_a [MEM_N];
    logic [31:0] mem_d [MEM_N];
    int          mem_n;

    ev_t         q[$];
    int          n_chk;
    int          n_fail;

    logic        s_ack, s_fault, s_rd, s_we;
    logic [31:0] s_data, s_base, s_pfa;
    logic [1:0]  s_pfc;

    always #5 clk = ~clk;

    mmu_utlb #(.ENTRIES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .mmu_base_i      (mmu_base_i),
        .mmu_we          (mmu_we),
        .mmu_base_o      (mmu_base_o),
        .v_addr_i        (v_addr_i),
        .v_data_i        (v_data_i),
        .v_data_o        (v_data_o),
        .v_we_i          (v_we_i),
        .v_rd_i          (v_rd_i),
        .v_ack_o         (v_ack_o),
        .addr_o          (addr_o),
        .data_i          (data_i),
        .data_o          (data_o),
        .we_o            (we_o),
        .rd_o            (rd_o),
        .ack_i           (ack_i),
        .page_fault      (page_fault),
        .page_fault_addr (page_fault_addr),
        .page_fault_code (page_fault_code)
    );

    // Zero-wait memory: unknown addresses read as 0 (an invalid descriptor)
    always_comb begin
        data_i = 32'h0;
        for (int i = 0; i < MEM_N; i++) begin
            if (i < mem_n && mem_a[i] == addr_o) data_i = mem_d[i];
        end
        ack_i = init_ack | (mem_on & ~mem_stall & (rd_o | we_o));
    end

    task automatic mem_put(input logic [31:0] a, input logic [31:0] d);
        mem_a[mem_n] = a;
        mem_d[mem_n] = d;
        mem_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.code = c;
        q.push_back(e);
    endtask

    task automatic take_ev(input logic [1:0] k, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] c);
        ev_t e;
        n_chk++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_event: observed kind %0d addr %h expected none", k, a);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("ev_kind", 32'(k), 32'(e.kind));
            chk("ev_addr", a, e.addr);
            if (k == K_WR)  chk("ev_wdata", d, e.data);
            if (k == K_FLT) chk("ev_code", 32'(c), 32'(e.code));
        end
    endtask

    // One clock: sample at the falling edge, then step past the rising edge
    task automatic cycle();
        @(negedge clk);
        s_ack   = v_ack_o;
        s_data  = v_data_o;
        s_fault = page_fault;
        s_rd    = rd_o;
        s_we    = we_o;
        s_base  = mmu_base_o;
        s_pfa   = page_fault_addr;
        s_pfc   = page_fault_code;
        if ((rd_o | we_o) && ack_i) take_ev(we_o ? K_WR : K_RD, addr_o, data_o, 2'd0);
        if (page_fault) take_ev(K_FLT, page_fault_addr, 32'h0, page_fault_code);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        s_ack = 1'b0;
        while (!s_ack && n < 40) begin
            cycle();
            n++;
        end
        n_chk++;
        assert (s_ack) else begin
            n_fail++;
            $error("FAIL ack_timeout: observed no ack after %0d cycles expected ack", n);
        end
        v_rd_i = 1'b0;
        v_we_i = 1'b0;
    endtask

    task automatic access(input logic [31:0] va, input logic wr, input logic [31:0] wd,
                          output int n, output logic [31:0] d);
        v_addr_i = va;
        v_data_i = wd;
        v_we_i   = wr;
        v_rd_i   = ~wr;
        wait_ack(n);
        d = s_data;
    endtask

    task automatic set_base(input logic [31:0] b);
        mmu_base_i = b;
        mmu_we     = 1'b1;
        cycle();
        mmu_we     = 1'b0;
    endtask

    initial begin
        int          n;
        logic [31:0] d;
        logic [31:0] va;

        n_chk = 0; n_fail = 0; mem_n = 0;
        for (int i = 0; i < MEM_N; i++) begin mem_a[i] = 32'h0; mem_d[i] = 32'h0; end
        rst = 1'b1; mmu_base_i = 32'h0; mmu_we = 1'b0;
        v_addr_i = 32'h0; v_data_i = 32'h0; v_we_i = 1'b0; v_rd_i = 1'b0;
        init_ack = 1'b0; mem_on = 1'b0; mem_stall = 1'b0;

        mem_put(32'h0001_0000, 32'h0002_0001);
        mem_put(32'h0001_0004, 32'h0000_0000);
        mem_put(32'h0002_0004, 32'h0034_5003);
        mem_put(32'h0034_5ABC, 32'hCAFE_BABE);
        mem_put(32'h0002_0008, 32'h0034_6001);
        for (int k = 0; k < 5; k++) mem_put(32'h0002_000C + 32'(4 * k), 32'h0040_0003 + 32'(k << 12));
        mem_put(32'h0005_0000, 32'h0006_0001);
        mem_put(32'h0006_0010, 32'h0050_0003);
        mem_put(32'h0006_000C, 32'h0050_1003);

        repeat (2) cycle();
        rst = 1'b0;

        // INIT: request ignored until the memory-ready pulse
        v_addr_i = 32'h0000_1000; v_rd_i = 1'b1;
        cycle();
        chk("init_rd_o", 32'(s_rd), 32'd0);
        chk("init_we_o", 32'(s_we), 32'd0);
        chk("init_ack", 32'(s_ack), 32'd0);
        chk("rst_base", s_base, 32'h0);
        chk("rst_pf", 32'(s_fault), 32'd0);
        chk("rst_pfa", s_pfa, 32'h0);
        chk("rst_pfc", 32'(s_pfc), 32'd0);
        v_rd_i = 1'b0;
        init_ack = 1'b1;
        cycle();
        init_ack = 1'b0;
        mem_on = 1'b1;

`ifdef MMU_BYPASS_EN
        expect_ev(K_RD, 32'h1234_5678, 32'h0, 2'd0);
        access(32'h1234_5678, 1'b0, 32'h0, n, d);
        chk("bypass_latency", 32'(n), 32'd1);
`else
        expect_ev(K_RD, 32'h0000_0120, 32'h0, 2'd0);
        expect_ev(K_FLT, 32'h1234_5678, 32'h0, 2'd1);
        access(32'h1234_5678, 1'b0, 32'h0, n, d);
        chk("base0_walk_cycles", 32'(n), 32'd2);
`endif
        set_base(32'h0001_0001);
        chk("base_set", mmu_base_o, 32'h0001_0001);

        // Same read now walks from the new base and hits an invalid PDE
        expect_ev(K_RD, 32'h0001_0120, 32'h0, 2'd0);
        expect_ev(K_FLT, 32'h1234_5678, 32'h0, 2'd1);
        access(32'h1234_5678, 1'b0, 32'h0, n, d);
        chk("walk_fault_cycles", 32'(n), 32'd2);

        // Two-level walk, fill, then translated read
        expect_ev(K_RD, 32'h0001_0000, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0002_0004, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0034_5ABC, 32'h0, 2'd0);
        access(32'h0000_1ABC, 1'b0, 32'h0, n, d);
        chk("miss_cycles", 32'(n), 32'd5);
        chk("miss_rdata", d, 32'hCAFE_BABE);
        expect_ev(K_RD, 32'h0034_5ABC, 32'h0, 2'd0);
        access(32'h0000_1ABC, 1'b0, 32'h0, n, d);
        chk("hit_cycles", 32'(n), 32'd1);
        chk("hit_rdata", d, 32'hCAFE_BABE);

        // Invalid PDE: fault code 1, held address, no fill
        expect_ev(K_RD, 32'h0001_0004, 32'h0, 2'd0);
        expect_ev(K_FLT, 32'h0040_0000, 32'h0, 2'd1);
        access(32'h0040_0000, 1'b0, 32'h0, n, d);
        chk("pde_fault_ack", 32'(s_fault), 32'd1);
        chk("pde_fault_cycles", 32'(n), 32'd2);
        cycle();
        chk("pf_pulse_low", 32'(page_fault), 32'd0);
        chk("pfa_held", page_fault_addr, 32'h0040_0000);
        chk("pfc_held", 32'(page_fault_code), 32'd1);
        expect_ev(K_RD, 32'h0001_0004, 32'h0, 2'd0);
        expect_ev(K_FLT, 32'h0040_0000, 32'h0, 2'd1);
        access(32'h0040_0000, 1'b0, 32'h0, n, d);
        chk("pde_nofill_cycles", 32'(n), 32'd2);

        // Read-only page: walk fills, the write faults without touching the bus
        expect_ev(K_RD, 32'h0001_0000, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0002_0008, 32'h0, 2'd0);
        expect_ev(K_FLT, 32'h0000_2000, 32'h0, 2'd3);
        access(32'h0000_2000, 1'b1, 32'h0000_0011, n, d);
        chk("wp_cycles", 32'(n), 32'd5);
        chk("wp_fault", 32'(s_fault), 32'd1);
        chk("wp_code", 32'(s_pfc), 32'd3);
        expect_ev(K_RD, 32'h0034_6010, 32'h0, 2'd0);
        access(32'h0000_2010, 1'b0, 32'h0, n, d);
        chk("ro_read_hit", 32'(n), 32'd1);

        // Flush, then five pages through four entries
        set_base(32'h0001_0001);
        for (int k = 0; k < 5; k++) begin
            va = 32'h0000_3000 + 32'(k << 12);
            expect_ev(K_RD, 32'h0001_0000, 32'h0, 2'd0);
            expect_ev(K_RD, 32'h0002_000C + 32'(4 * k), 32'h0, 2'd0);
            expect_ev(K_RD, 32'h0040_0000 + 32'(k << 12), 32'h0, 2'd0);
            access(va, 1'b0, 32'h0, n, d);
            chk("fill_cycles", 32'(n), 32'd5);
        end
        for (int k = 1; k < 5; k++) begin
            expect_ev(K_RD, 32'h0040_0000 + 32'(k << 12), 32'h0, 2'd0);
            access(32'h0000_3000 + 32'(k << 12), 1'b0, 32'h0, n, d);
            chk("resident_hit", 32'(n), 32'd1);
        end
        expect_ev(K_WR, 32'h0040_2044, 32'hA5A5_0003, 2'd0);
        access(32'h0000_5044, 1'b1, 32'hA5A5_0003, n, d);
        chk("write_hit", 32'(n), 32'd1);
        expect_ev(K_RD, 32'h0001_0000, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0002_000C, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0040_0000, 32'h0, 2'd0);
        access(32'h0000_3000, 1'b0, 32'h0, n, d);
        chk("evicted_rewalk", 32'(n), 32'd5);

        // Base change while the PTE read is outstanding
        expect_ev(K_RD, 32'h0001_0000, 32'h0, 2'd0);
        v_addr_i = 32'h0000_4000; v_rd_i = 1'b1;
        cycle();
        cycle();
        mem_stall = 1'b1;
        mmu_base_i = 32'h0005_0001; mmu_we = 1'b1;
        cycle();
        chk("abort_no_ack", 32'(s_ack), 32'd0);
        chk("abort_no_fault", 32'(s_fault), 32'd0);
        mmu_we = 1'b0; mem_stall = 1'b0;
        chk("abort_base", mmu_base_o, 32'h0005_0001);
        expect_ev(K_RD, 32'h0005_0000, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0006_0010, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0050_0000, 32'h0, 2'd0);
        wait_ack(n);
        chk("rewalk_cycles", 32'(n), 32'd5);
        expect_ev(K_RD, 32'h0005_0000, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0006_0014, 32'h0, 2'd0);
        expect_ev(K_FLT, 32'h0000_5000, 32'h0, 2'd2);
        access(32'h0000_5000, 1'b0, 32'h0, n, d);
        chk("pte_fault_cycles", 32'(n), 32'd3);
        expect_ev(K_RD, 32'h0005_0000, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0006_000C, 32'h0, 2'd0);
        expect_ev(K_RD, 32'h0050_1000, 32'h0, 2'd0);
        access(32'h0000_3000, 1'b0, 32'h0, n, d);
        chk("flushed_miss", 32'(n), 32'd5);

        // Reset in the middle of a walk
        mem_stall = 1'b1;
        v_addr_i = 32'h0000_8000; v_rd_i = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        chk("walk_rd_before_rst", 32'(s_rd), 32'd1);
        rst = 1'b0;
        cycle();
        chk("rst_walk_rd_o", 32'(s_rd), 32'd0);
        chk("rst_walk_base", s_base, 32'h0);
        chk("rst_walk_ack", 32'(s_ack), 32'd0);
        v_rd_i = 1'b0;

        chk("events_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
